// File: rtl/sdiv_pkg.sv
// ============================================================================
// Module   : sdiv_pkg
// Brief    : Shared state encoding and constants for the sdiv_unit divider.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdiv_pkg;

    localparam int unsigned c_xlen_default = 32;

    // Held MSB-aligned at 64 bits; the divider slices off its own XLEN.
    localparam logic [63:0] c_most_neg = 64'h8000_0000_0000_0000;
    localparam logic [63:0] c_dz_quot  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_CALC = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } sdiv_state_t;

endpackage

`default_nettype wire

// File: rtl/sdiv_step.sv
// ============================================================================
// Module   : sdiv_step
// Brief    : One combinational restoring shift-subtract iteration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdiv_step #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dividend_bit,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            quot_bit
);

    logic [XLEN:0] w_shifted;
    logic [XLEN:0] w_diff;

    assign w_shifted = {rem_in, dividend_bit};
    assign w_diff    = w_shifted - {1'b0, divisor};

    // A borrow out of the top bit means the divisor did not fit: restore.
    assign quot_bit = ~w_diff[XLEN];
    assign rem_out  = w_diff[XLEN] ? w_shifted[XLEN-1:0] : w_diff[XLEN-1:0];

endmodule

`default_nettype wire

// File: rtl/sdiv_unit.sv
// ============================================================================
// Module   : sdiv_unit
// Brief    : Multi-cycle restoring divider; two's-complement support is
//            compiled in only when SDIV_SIGNED_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdiv_unit
    import sdiv_pkg::*;
#(
    parameter int unsigned XLEN = c_xlen_default
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    input  logic            is_signed,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder,
    output logic            zero_flag,
    output logic            negative_flag,
    output logic            carry_flag,
    output logic            overflow_flag
);

    localparam logic [XLEN-1:0] c_most_neg_x = c_most_neg[63 -: XLEN];
    localparam logic [XLEN-1:0] c_dz_quot_x  = c_dz_quot[XLEN-1:0];
    localparam logic [XLEN-1:0] c_sat_quot   = ~c_most_neg_x;
    localparam logic [5:0]      c_last_iter  = 6'(XLEN - 1);

    sdiv_state_t     r_state;
    logic [5:0]      r_cnt;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_rem;
    logic [XLEN-1:0] r_acc;
    logic [XLEN-1:0] r_dvs;

    logic [XLEN-1:0] w_rem_nxt;
    logic            w_q_bit;
    logic            w_is_ovf;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic [XLEN-1:0] w_q_fin;
    logic [XLEN-1:0] w_r_fin;

    sdiv_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_in       (r_rem),
        .dividend_bit (r_acc[XLEN-1]),
        .divisor      (r_dvs),
        .rem_out      (w_rem_nxt),
        .quot_bit     (w_q_bit)
    );

`ifdef SDIV_SIGNED_EN
    logic r_sgn;
    logic r_q_neg;
    logic r_r_neg;
    logic r_ovf;
    logic w_a_neg;
    logic w_b_neg;

    assign w_a_neg  = r_sgn & r_a[XLEN-1];
    assign w_b_neg  = r_sgn & r_b[XLEN-1];
    assign w_is_ovf = r_sgn && (r_a == c_most_neg_x) && (r_b == '1);
    assign w_a_mag  = w_a_neg ? -r_a : r_a;
    assign w_b_mag  = w_b_neg ? -r_b : r_b;
    assign w_q_fin  = r_q_neg ? -r_acc : r_acc;
    assign w_r_fin  = r_r_neg ? -r_rem : r_rem;
    assign overflow_flag = r_ovf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sgn   <= 1'b0;
            r_q_neg <= 1'b0;
            r_r_neg <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_sgn <= is_signed;
            end
            if (r_state == ST_PREP) begin
                r_q_neg <= w_a_neg ^ w_b_neg;
                r_r_neg <= w_a_neg;
                // Only the special-case paths publish a result from PREP.
                if (r_b == '0) begin
                    r_ovf <= 1'b0;
                end else if (w_is_ovf) begin
                    r_ovf <= 1'b1;
                end
            end
            if (r_state == ST_FIX) begin
                r_ovf <= 1'b0;
            end
        end
    end
`else
    logic w_unused_sign;

    assign w_unused_sign = is_signed;
    assign w_is_ovf      = 1'b0;
    assign w_a_mag       = r_a;
    assign w_b_mag       = r_b;
    assign w_q_fin       = r_acc;
    assign w_r_fin       = r_rem;
    assign overflow_flag = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_a           <= '0;
            r_b           <= '0;
            r_rem         <= '0;
            r_acc         <= '0;
            r_dvs         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            quotient      <= '0;
            remainder     <= '0;
            zero_flag     <= 1'b0;
            negative_flag <= 1'b0;
            carry_flag    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_a     <= dividend;
                        r_b     <= divisor;
                        busy    <= 1'b1;
                        r_state <= ST_PREP;
                    end
                end
                ST_PREP: begin
                    if (r_b == '0) begin
                        quotient      <= c_dz_quot_x;
                        remainder     <= r_a;
                        zero_flag     <= 1'b0;
                        negative_flag <= c_dz_quot_x[XLEN-1];
                        carry_flag    <= 1'b1;
                        done          <= 1'b1;
                        r_state       <= ST_DONE;
                    end else if (w_is_ovf) begin
                        quotient      <= c_sat_quot;
                        remainder     <= '0;
                        zero_flag     <= 1'b0;
                        negative_flag <= c_sat_quot[XLEN-1];
                        carry_flag    <= 1'b0;
                        done          <= 1'b1;
                        r_state       <= ST_DONE;
                    end else begin
                        r_acc   <= w_a_mag;
                        r_dvs   <= w_b_mag;
                        r_rem   <= '0;
                        r_cnt   <= '0;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // r_acc shifts dividend bits out the top and quotient bits in.
                    r_rem <= w_rem_nxt;
                    r_acc <= {r_acc[XLEN-2:0], w_q_bit};
                    r_cnt <= r_cnt + 6'd1;
                    if (r_cnt == c_last_iter) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    quotient      <= w_q_fin;
                    remainder     <= w_r_fin;
                    zero_flag     <= (w_q_fin == '0);
                    negative_flag <= w_q_fin[XLEN-1];
                    carry_flag    <= 1'b0;
                    done          <= 1'b1;
                    r_state       <= ST_DONE;
                end
                ST_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdiv_unit.sv
// ============================================================================
// Module   : tb_sdiv_unit
// Brief    : Directed-vector bench for sdiv_unit (XLEN = 32).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdiv_unit;

    localparam int unsigned XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            start;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            is_signed;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] quotient;
    logic [XLEN-1:0] remainder;
    logic            zero_flag;
    logic            negative_flag;
    logic            carry_flag;
    logic            overflow_flag;

    int n_cmp = 0;
    int n_err = 0;

    sdiv_unit #(
        .XLEN(XLEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .is_signed     (is_signed),
        .busy          (busy),
        .done          (done),
        .quotient      (quotient),
        .remainder     (remainder),
        .zero_flag     (zero_flag),
        .negative_flag (negative_flag),
        .carry_flag    (carry_flag),
        .overflow_flag (overflow_flag)
    );

    always #5 clk = ~clk;

    // flags packed as {zero, negative, carry, overflow}
    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        sg;
        logic [31:0] q;
        logic [31:0] r;
        logic [3:0]  f;
        int          lat;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] flags();
        return {zero_flag, negative_flag, carry_flag, overflow_flag};
    endfunction

    // Latency = rising edges after the accepting edge until done is seen high.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg,
                          input logic [31:0] eq, input logic [31:0] er,
                          input logic [3:0] ef, input int elat, input string tag);
        int n;
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = sg;
        start     = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk({tag, " busy"}, 32'(busy), 32'd1);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!done && n < 100);
        chk({tag, " latency"}, n, elat);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " flags"}, 32'(flags()), 32'(ef));
        @(posedge clk);
        #1;
        chk({tag, " done_drop"}, 32'(done), 32'd0);
        chk({tag, " q_hold"}, quotient, eq);
    endtask

    initial begin
        int pulses;
        int done_at;
        logic [31:0] q_seen;
        logic [31:0] r_seen;
        logic busy_after;

        vecs[0] = '{32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 4'b0000, 34};
        vecs[2] = '{32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 4'b0110, 1};
        vecs[4] = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 4'b1000, 34};
        vecs[7] = '{32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0, 4'b0100, 34};
        vecs[8] = '{32'd12345, 32'd123, 1'b0, 32'd100, 32'd45, 4'b0000, 34};
        vecs[9] = '{32'hFFFF_FFF8, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF8, 4'b0110, 1};
`ifdef SDIV_SIGNED_EN
        vecs[1]  = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 4'b0100, 34};
        vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h7FFF_FFFF, 32'd0, 4'b0001, 1};
        vecs[5]  = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 4'b0100, 34};
        vecs[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd3, 32'hFFFF_FFFF, 4'b0000, 34};
        vecs[10] = '{32'h8000_0000, 32'd2, 1'b1, 32'hC000_0000, 32'd0, 4'b0100, 34};
`else
        vecs[1]  = '{32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 4'b0000, 34};
        vecs[3]  = '{32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'd0, 32'h8000_0000, 4'b1000, 34};
        vecs[5]  = '{32'd7, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'd7, 4'b1000, 34};
        vecs[6]  = '{32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1, 32'd0, 32'hFFFF_FFF9, 4'b1000, 34};
        vecs[10] = '{32'h8000_0000, 32'd2, 1'b1, 32'h4000_0000, 32'd0, 4'b0000, 34};
`endif

        rst       = 1'b1;
        start     = 1'b0;
        dividend  = '0;
        divisor   = '0;
        is_signed = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset quotient", quotient, 32'd0);
        chk("reset remainder", remainder, 32'd0);
        chk("reset flags", 32'(flags()), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sg, vecs[i].q, vecs[i].r,
                   vecs[i].f, vecs[i].lat, $sformatf("vec%0d", i));
        end

        // Abort mid-CALC: edge 1 enters CALC, edges 2..10 run iterations 1..9.
        run_op(32'd5, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd5, 4'b0110, 1, "pre_abort");
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort quotient", quotient, 32'd0);
        chk("abort remainder", remainder, 32'd0);
        chk("abort flags", 32'(flags()), 32'd0);
        rst = 1'b0;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        chk("abort no_done", pulses, 0);
        run_op(32'd0, 32'd3, 1'b0, 32'd0, 32'd0, 4'b1000, 34, "zero_div");

        // Reset wins over a simultaneous start.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; dividend = 32'd9; divisor = 32'd3;
        @(posedge clk);
        #1;
        chk("rst_vs_start busy", 32'(busy), 32'd0);
        rst = 1'b0; start = 1'b0;

        // Start re-pulsed in CALC and in the DONE cycle must both be ignored.
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; is_signed = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pulses = 0; done_at = -10; q_seen = '0; r_seen = '0; busy_after = 1'b1;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            if (i == done_at + 2) busy_after = busy;
            if (done) begin
                pulses++;
                done_at  = i;
                q_seen   = quotient;
                r_seen   = remainder;
                dividend = 32'd9; divisor = 32'd3; start = 1'b1;
            end else if (i == 5 || i == 20) begin
                dividend = 32'd50; divisor = 32'd5; start = 1'b1;
            end
        end
        chk("repulse done_count", pulses, 1);
        chk("repulse done_edge", done_at, 34);
        chk("repulse quotient", q_seen, 32'd14);
        chk("repulse remainder", r_seen, 32'd2);
        chk("repulse idle_after_done", 32'(busy_after), 32'd0);
        chk("repulse q_hold", quotient, 32'd14);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
